// File: rtl/joybus_pkg.sv
// Shared types and default timing for the Joybus response receiver.
package joybus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        VOTE,
        SHIFT,
        STOP_FALL,
        STOP,
        ERR
    } jb_rx_state_t;

    localparam int JB_CLKS_PER_BIT_DEF = 200;
    localparam int JB_STOP_CLKS_DEF    = 100;

endpackage

// File: rtl/jb_bit_voter.sv
// Low/high sample counter for one fixed-length window; decides a bit by majority (tie -> 0).
module jb_bit_voter #(
    parameter int CLKS_PER_BIT = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic sample,
    output logic win_done,
    output logic bit_val
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW:0] LIMIT = CLKS_PER_BIT[CW:0];

    logic [CW-1:0] lo, hi, lo_nxt, hi_nxt;

    // clr and en together restart the window with the current sample as its first vote
    always_comb begin
        lo_nxt = clr ? '0 : lo;
        hi_nxt = clr ? '0 : hi;
        if (en) begin
            if (sample) hi_nxt = hi_nxt + 1'b1;
            else        lo_nxt = lo_nxt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo <= '0;
            hi <= '0;
        end else begin
            lo <= lo_nxt;
            hi <= hi_nxt;
        end
    end

    // Done as soon as the sample being taken fills the window, so the caller loses no cycle.
    assign win_done = ({1'b0, lo_nxt} + {1'b0, hi_nxt}) == LIMIT;
    assign bit_val  = hi > lo;

endmodule

// File: rtl/joybus_rx_multi.sv
// Variable-length Joybus reply receiver with per-bit falling-edge re-alignment.
// Optional wait timeout in WAIT_FALL/STOP_FALL enabled by defining JB_RX_TIMEOUT_EN.
module joybus_rx_multi
    import joybus_pkg::*;
#(
    parameter int CLKS_PER_BIT = JB_CLKS_PER_BIT_DEF,
    parameter int STOP_CLKS    = JB_STOP_CLKS_DEF,
    parameter int MAX_BITS     = 64,
    parameter int TIMEOUT_CLKS = 5000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          jb_rx,
    input  logic                          rx_start,
    input  logic [$clog2(MAX_BITS+1)-1:0] rx_len,
    output logic                          rx_busy,
    output logic                          rx_done,
    output logic                          rx_err,
    output logic [MAX_BITS-1:0]           rx_data,
    output logic [$clog2(MAX_BITS+1)-1:0] rx_bit_cnt
);

    localparam int LW = $clog2(MAX_BITS + 1);

    jb_rx_state_t state, state_nxt;
    logic         ff1, ff2, ff3, fall;
    logic [LW-1:0] len_q;
    logic         en_bit, en_stop, bit_done, stop_done, bit_val, stop_vote_unused;
    logic         last, len_bad, timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {ff1, ff2, ff3} <= 3'b111;
        else        {ff1, ff2, ff3} <= {jb_rx, ff1, ff2};
    end

    // ff3 is the older sample: high-then-low is the falling edge
    assign fall    = ff3 & ~ff2;
    assign last    = (rx_bit_cnt + LW'(1)) == len_q;
    assign len_bad = (rx_len == '0) || (rx_len > LW'(MAX_BITS));
    assign rx_busy = (state != IDLE);

`ifdef JB_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] wait_cnt;
    logic          waiting;

    assign waiting = (state == WAIT_FALL) || (state == STOP_FALL);
    assign timeout = waiting && !fall && (wait_cnt == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wait_cnt <= '0;
        else if (waiting && !fall) wait_cnt <= wait_cnt + 1'b1;
        else                       wait_cnt <= '0;
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CLKS;
    assign timeout = 1'b0;
`endif

    jb_bit_voter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_vote (
        .clk(clk), .rst_n(rst_n), .clr(state != VOTE), .en(en_bit),
        .sample(ff2), .win_done(bit_done), .bit_val(bit_val)
    );

    jb_bit_voter #(.CLKS_PER_BIT(STOP_CLKS)) u_stop_vote (
        .clk(clk), .rst_n(rst_n), .clr(state != STOP), .en(en_stop),
        .sample(ff2), .win_done(stop_done), .bit_val(stop_vote_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A fall landing in SHIFT opens the next window at once, so back-to-back
    // CLKS_PER_BIT-long symbols keep every aligning edge.
    always_comb begin
        state_nxt = state;
        en_bit    = 1'b0;
        en_stop   = 1'b0;
        case (state)
            IDLE:      if (rx_start) state_nxt = len_bad ? ERR : WAIT_FALL;
            WAIT_FALL: begin
                if (fall) begin
                    en_bit    = 1'b1;
                    state_nxt = VOTE;
                end else if (timeout) state_nxt = ERR;
            end
            VOTE: begin
                en_bit = 1'b1;
                if (bit_done) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last) begin
                    en_stop   = fall;
                    state_nxt = fall ? STOP : STOP_FALL;
                end else begin
                    en_bit    = fall;
                    state_nxt = fall ? VOTE : WAIT_FALL;
                end
            end
            STOP_FALL: begin
                if (fall) begin
                    en_stop   = 1'b1;
                    state_nxt = STOP;
                end else if (timeout) state_nxt = ERR;
            end
            STOP: begin
                en_stop = 1'b1;
                if (stop_done) state_nxt = IDLE;
            end
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            rx_data    <= '0;
            rx_bit_cnt <= '0;
            rx_err     <= 1'b0;
            rx_done    <= 1'b0;
        end else begin
            rx_done <= ((state == STOP) && stop_done) || (state == ERR);
            if ((state == IDLE) && rx_start) begin
                len_q      <= rx_len;
                rx_data    <= '0;
                rx_bit_cnt <= '0;
                rx_err     <= 1'b0;
            end
            if (state == SHIFT) begin
                rx_data    <= {rx_data[MAX_BITS-2:0], bit_val};
                rx_bit_cnt <= rx_bit_cnt + 1'b1;
            end
            if (state == ERR) rx_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_joybus_rx_multi.sv
// Directed + randomized bench for joybus_rx_multi; symbols are built from low/high durations.
module tb_joybus_rx_multi;

    localparam int CPB = 200;
    localparam int SC  = 100;
    localparam int MB  = 64;
    localparam int TO  = 5000;
    localparam int LW  = $clog2(MB + 1);

    logic          clk = 1'b0, rst_n = 1'b0, jb_rx = 1'b1, rx_start = 1'b0;
    logic [LW-1:0] rx_len = '0;
    logic          rx_busy, rx_done, rx_err;
    logic [MB-1:0] rx_data;
    logic [LW-1:0] rx_bit_cnt;

    int   vectors = 0, miscompares = 0, done_cnt = 0;
    logic done_err = 1'b0;

    joybus_rx_multi #(.CLKS_PER_BIT(CPB), .STOP_CLKS(SC), .MAX_BITS(MB), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst_n(rst_n), .jb_rx(jb_rx), .rx_start(rx_start), .rx_len(rx_len),
        .rx_busy(rx_busy), .rx_done(rx_done), .rx_err(rx_err), .rx_data(rx_data),
        .rx_bit_cnt(rx_bit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_done) begin
        done_cnt = done_cnt + 1;
        done_err = rx_err;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input int len);
        rx_len   = LW'(len);
        rx_start = 1'b1;
        tick(1);
        rx_start = 1'b0;
    endtask

    task automatic sym(input int lo, input int hi);
        jb_rx = 1'b0;
        tick(lo);
        jb_rx = 1'b1;
        tick(hi);
    endtask

    // 0 = 3/4 low, 1 = 1/4 low, scaled to the symbol length L
    task automatic send_bit(input logic b, input int L);
        int lo;
        lo = b ? L / 4 : (3 * L) / 4;
        sym(lo, L - lo);
    endtask

    task automatic wait_done(input int base, input int budget, output bit got);
        got = (done_cnt != base);
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = (done_cnt != base);
        end
        #1;
    endtask

    function automatic logic [63:0] mask(input int len);
        return (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
    endfunction

    // Full reception: model is the transmitted word, first bit landing at [len-1].
    task automatic recv(input string tag, input int len, input logic [63:0] pat,
                        input int lmin, input int lmax);
        int base;
        bit got;
        base = done_cnt;
        start(len);
        for (int i = len - 1; i >= 0; i--) send_bit(pat[i], $urandom_range(lmin, lmax));
        sym(CPB / 4, CPB - CPB / 4);
        wait_done(base, 400, got);
        chk({tag, "_done"}, 64'(got), 64'd1);
        chk({tag, "_once"}, 64'(done_cnt - base), 64'd1);
        chk({tag, "_err"}, 64'(done_err), 64'd0);
        chk({tag, "_data"}, rx_data, pat & mask(len));
        chk({tag, "_cnt"}, 64'(rx_bit_cnt), 64'(len));
        chk({tag, "_busy"}, 64'(rx_busy), 64'd0);
    endtask

    // Single-bit reception of an arbitrary low/high symbol; majority rule with tie -> 0.
    task automatic recv_raw(input string tag, input int lo, input int hi);
        int base;
        bit got;
        base = done_cnt;
        start(1);
        sym(lo, hi);
        sym(50, 150);
        wait_done(base, 400, got);
        chk({tag, "_done"}, 64'(got), 64'd1);
        chk({tag, "_data"}, rx_data, (hi > lo) ? 64'd1 : 64'd0);
    endtask

    initial begin
        logic [63:0] pat;
        int base, len;
        bit got;

        tick(3);
        chk("rst_busy", 64'(rx_busy), 64'd0);
        chk("rst_done", 64'(rx_done), 64'd0);
        chk("rst_err", 64'(rx_err), 64'd0);
        chk("rst_data", rx_data, 64'd0);
        chk("rst_cnt", 64'(rx_bit_cnt), 64'd0);
        rst_n = 1'b1;
        tick(3);

        recv("byte5a", 8, 64'h5A, CPB, CPB);

        pat = {$urandom(), $urandom()};
        recv("drift64", 64, pat, 220, 220);

        recv_raw("tie", 100, 100);
        recv_raw("hi101", 99, 101);

        for (int n = 0; n < 2; n++) begin
            start(n == 0 ? 0 : 65);
            chk("badlen_busy", 64'(rx_busy), 64'd1);
            tick(1);
            chk("badlen_done", 64'(rx_done), 64'd1);
            chk("badlen_err", 64'(rx_err), 64'd1);
            chk("badlen_data", rx_data, 64'd0);
            tick(1);
            chk("badlen_pulse", 64'(rx_done), 64'd0);
            chk("badlen_idle", 64'(rx_busy), 64'd0);
            chk("badlen_hold", 64'(rx_err), 64'd1);
        end

        for (int n = 0; n < 3; n++) begin
            len = $urandom_range(1, 24);
            pat = {$urandom(), $urandom()} & mask(len);
            recv("rand", len, pat, CPB, 220);
        end

        // line stays high after 10 of 32 bits
        pat  = 64'($urandom_range(0, 1023));
        base = done_cnt;
        start(32);
        for (int i = 9; i >= 0; i--) send_bit(pat[i], CPB);
`ifdef JB_RX_TIMEOUT_EN
        wait_done(base, TO + 400, got);
        chk("tmo_done", 64'(got), 64'd1);
        chk("tmo_err", 64'(done_err), 64'd1);
        chk("tmo_cnt", 64'(rx_bit_cnt), 64'd10);
        chk("tmo_data", rx_data, pat);
        chk("tmo_busy", 64'(rx_busy), 64'd0);
`else
        tick(TO + 1000);
        chk("stall_nodone", 64'(done_cnt - base), 64'd0);
        chk("stall_busy", 64'(rx_busy), 64'd1);
        chk("stall_cnt", 64'(rx_bit_cnt), 64'd10);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
`endif

        // reset in the middle of bit 5
        base = done_cnt;
        start(16);
        for (int i = 15; i > 11; i--) send_bit(1'b1, CPB);
        jb_rx = 1'b0;
        tick(60);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_busy", 64'(rx_busy), 64'd0);
        chk("midrst_data", rx_data, 64'd0);
        chk("midrst_cnt", 64'(rx_bit_cnt), 64'd0);
        chk("midrst_err", 64'(rx_err), 64'd0);
        jb_rx = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(300);
        chk("midrst_nodone", 64'(done_cnt - base), 64'd0);

        // rx_start while busy must not change the latched length
        base = done_cnt;
        start(8);
        send_bit(1'b1, CPB);
        send_bit(1'b0, CPB);
        start(1);
        chk("busy_start", 64'(rx_busy), 64'd1);
        for (int i = 5; i >= 0; i--) send_bit(i[0], CPB);
        sym(50, 150);
        wait_done(base, 400, got);
        chk("ign_done", 64'(got), 64'd1);
        chk("ign_once", 64'(done_cnt - base), 64'd1);
        chk("ign_cnt", 64'(rx_bit_cnt), 64'd8);
        chk("ign_data", rx_data, 64'b10101010);
        chk("ign_err", 64'(rx_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
